// File: rtl/store_queue.sv
// Store-side byte-lane packer and write FIFO feeding data memory over valid/ready.
// Optional tail merging of same-word stores is enabled by defining STORE_MERGE_EN.
module store_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [1:0]               storeOP,
    input  logic [31:0]              st_addr,
    input  logic [31:0]              st_data,
    output logic                     dm_valid,
    input  logic                     dm_ready,
    output logic [31:0]              dm_addr,
    output logic [31:0]              dm_wdata,
    output logic [3:0]               dm_be,
    output logic                     misalign,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        OP_SW  = 2'b00,
        OP_SB  = 2'b01,
        OP_SH  = 2'b10,
        OP_RSV = 2'b11
    } store_op_e;

    logic [31:0]   addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [3:0]    be_q   [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          misalign_q, misalign_d;

    store_op_e     op;
    logic [31:0]   word_addr;
    logic [31:0]   pk_data;
    logic [3:0]    pk_be;
    logic          pk_aligned;
    logic          pk_is_store;
    logic          accept, push_req, alloc, merge, pop, empty, full;

    assign op        = store_op_e'(storeOP);
    assign word_addr = {st_addr[31:2], 2'b00};

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        pk_data     = st_data;
        pk_be       = 4'b0000;
        pk_aligned  = 1'b0;
        pk_is_store = 1'b1;
        case (op)
            OP_SW: begin
                pk_be      = 4'b1111;
                pk_aligned = (st_addr[1:0] == 2'b00);
            end
            OP_SH: begin
                pk_data    = {2{st_data[15:0]}};
                pk_be      = st_addr[1] ? 4'b1100 : 4'b0011;
                pk_aligned = ~st_addr[0];
            end
            OP_SB: begin
                pk_data    = {4{st_data[7:0]}};
                pk_be      = 4'b0001 << st_addr[1:0];
                pk_aligned = 1'b1;
            end
            default: pk_is_store = 1'b0;
        endcase
    end

    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_CNT);
    assign accept   = st_valid && !full;
    assign pop      = !empty && dm_ready;
    assign push_req = accept && pk_is_store && pk_aligned;

`ifdef STORE_MERGE_EN
    logic [AW-1:0] tail_idx;
    assign tail_idx = wr_ptr_q - AW'(1);
    // A lone entry that is leaving this cycle cannot absorb the new store.
    assign merge = push_req && !empty && (addr_q[tail_idx] == word_addr)
                   && !(pop && count_q == (AW+1)'(1));
`else
    assign merge = 1'b0;
`endif
    assign alloc = push_req && !merge;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q + (AW+1)'(alloc) - (AW+1)'(pop);
        misalign_d = accept && pk_is_store && !pk_aligned;
        if (alloc) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
    end

    // NOTE: storage is reset because the head entry drives dm_* directly and must read zero out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            misalign_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                be_q[i]   <= '0;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
            if (alloc) begin
                addr_q[wr_ptr_q] <= word_addr;
                data_q[wr_ptr_q] <= pk_data;
                be_q[wr_ptr_q]   <= pk_be;
            end
`ifdef STORE_MERGE_EN
            if (merge) begin
                be_q[tail_idx] <= be_q[tail_idx] | pk_be;
                for (int b = 0; b < 4; b++) begin
                    if (pk_be[b]) data_q[tail_idx][8*b +: 8] <= pk_data[8*b +: 8];
                end
            end
`endif
        end
    end

    assign st_ready = !full;
    assign dm_valid = !empty;
    assign dm_addr  = addr_q[rd_ptr_q];
    assign dm_wdata = data_q[rd_ptr_q];
    assign dm_be    = be_q[rd_ptr_q];
    assign misalign = misalign_q;
    assign count    = count_q;

endmodule
